// File: rtl/hpi_pio_pkg.sv
// Shared constants for the HPI parallel I/O block: register addresses
// and edge-capture modes.
package hpi_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISE = 32'sd0;
   localparam int EDGE_FALL = 32'sd1;
   localparam int EDGE_ANY  = 32'sd2;

endpackage

// File: rtl/hpi_pio_ext_if.sv
// Slave bus bundle of the HPI parallel I/O block.
interface hpi_pio_ext_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, output chipselect, output write_n,
                   output writedata, input readdata);
   modport slave  (input address, input chipselect, input write_n,
                   input writedata, output readdata);
endinterface

// File: rtl/hpi_pio_sync_edge.sv
// Input synchroniser, edge history and per-bit edge pulses; pulses are held off
// until the synchroniser has refilled after reset.
module hpi_pio_sync_edge
   import hpi_pio_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_data,
   output logic [WIDTH-1:0] edge_pulse
);

   localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] prev_r;
   logic [2:0]       arm_cnt_r;
   logic             armed_s;
   logic [WIDTH-1:0] cond_s;

   // synchroniser shift chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      end else begin
         sync_r[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   // edge history; it keeps tracking during the arm window so a level already
   // present at reset release never looks like an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_r    <= '0;
         arm_cnt_r <= 3'd0;
      end else begin
         prev_r <= sync_r[SYNC_STAGES-1];
         if (!armed_s) arm_cnt_r <= arm_cnt_r + 3'd1;
         else          arm_cnt_r <= arm_cnt_r;
      end
   end

   // per-bit edge condition for the selected mode
   always_comb begin
      cond_s = '0;
      case (EDGE_TYPE)
         EDGE_RISE: cond_s = ~prev_r & sync_r[SYNC_STAGES-1];
         EDGE_FALL: cond_s = prev_r & ~sync_r[SYNC_STAGES-1];
         default:   cond_s = prev_r ^ sync_r[SYNC_STAGES-1];
      endcase
   end

   assign armed_s    = (arm_cnt_r == ARM_COUNT);
   assign edge_pulse = armed_s ? cond_s : '0;
   assign sync_data  = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/hpi_pio_ext.sv
// HPI parallel I/O port: output/direction/mask registers, sticky edge capture
// with write-1-to-clear, registered interrupt and registered read mux.
module hpi_pio_ext
   import hpi_pio_pkg::*;
#(
   parameter int             WIDTH       = 16,
   parameter int             EDGE_TYPE   = 0,
   parameter int             SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   hpi_pio_ext_if.slave     bus,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   logic [WIDTH-1:0] out_r, dir_r, mask_r, cap_r;
   logic [WIDTH-1:0] out_nxt_s, dir_nxt_s, mask_nxt_s, cap_clr_s, cap_nxt_s;
   logic [WIDTH-1:0] sync_s, edge_s, wd_s;
   logic [31:0]      readdata_r, rd_nxt_s;
   logic             irq_r, wr_s, wd_unused_s;

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r          = 32'd0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   hpi_pio_sync_edge #(
      .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)
   ) u_sync_edge (
      .clk(clk), .reset_n(reset_n), .async_in(in_port),
      .sync_data(sync_s), .edge_pulse(edge_s)
   );

   assign wr_s        = bus.chipselect & ~bus.write_n;
   assign wd_s        = bus.writedata[WIDTH-1:0];
   assign wd_unused_s = ^bus.writedata;

   // register write decode
   always_comb begin
      out_nxt_s  = out_r;
      dir_nxt_s  = dir_r;
      mask_nxt_s = mask_r;
      cap_clr_s  = '0;
      if (wr_s) begin
         case (bus.address)
            ADDR_DATA:    out_nxt_s  = wd_s;
            ADDR_DIR:     dir_nxt_s  = wd_s;
            ADDR_IRQMASK: mask_nxt_s = wd_s;
            ADDR_EDGECAP: cap_clr_s  = wd_s;
            ADDR_OUTSET:  out_nxt_s  = out_r | wd_s;
            ADDR_OUTCLR:  out_nxt_s  = out_r & ~wd_s;
            default:      out_nxt_s  = out_r;
         endcase
      end else begin
         cap_clr_s = '0;
      end
      // a fresh edge overrides a same-cycle clear
      cap_nxt_s = (cap_r & ~cap_clr_s) | edge_s;
   end

   // read mux
   always_comb begin
      rd_nxt_s = 32'd0;
      case (bus.address)
         ADDR_DATA:    rd_nxt_s = zext(sync_s);
         ADDR_DIR:     rd_nxt_s = zext(dir_r);
         ADDR_IRQMASK: rd_nxt_s = zext(mask_r);
         ADDR_EDGECAP: rd_nxt_s = zext(cap_r);
         default:      rd_nxt_s = 32'd0;
      endcase
   end

   // register file, read data and interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_r      <= RESET_OUT;
         dir_r      <= '0;
         mask_r     <= '0;
         cap_r      <= '0;
         readdata_r <= 32'd0;
         irq_r      <= 1'b0;
      end else begin
         out_r      <= out_nxt_s;
         dir_r      <= dir_nxt_s;
         mask_r     <= mask_nxt_s;
         cap_r      <= cap_nxt_s;
         readdata_r <= rd_nxt_s;
         irq_r      <= |(cap_r & mask_r);
      end
   end

   assign bus.readdata = readdata_r;
   assign out_port     = out_r;
   assign oe           = dir_r;
   assign irq          = irq_r;

endmodule

// File: tb/tb_hpi_pio_ext.sv
// Directed bench: a 16-bit rising-edge instance, a 16-bit any-edge instance and
// an 8-bit instance share one bus stimulus and one in_port.
module tb_hpi_pio_ext;
   import hpi_pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [15:0] in_port;

   logic [15:0] out16, oe16, out_any, oe_any;
   logic [7:0]  out8, oe8;
   logic        irq16, irq_any, irq8;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] d;

   hpi_pio_ext_if bus16 ();
   hpi_pio_ext_if bus_any ();
   hpi_pio_ext_if bus8 ();

   assign bus16.address   = address;   assign bus_any.address   = address;   assign bus8.address   = address;
   assign bus16.chipselect = chipselect; assign bus_any.chipselect = chipselect; assign bus8.chipselect = chipselect;
   assign bus16.write_n   = write_n;   assign bus_any.write_n   = write_n;   assign bus8.write_n   = write_n;
   assign bus16.writedata = writedata; assign bus_any.writedata = writedata; assign bus8.writedata = writedata;

   hpi_pio_ext #(.WIDTH(16), .EDGE_TYPE(0), .SYNC_STAGES(2), .RESET_OUT(16'h00A5)) dut16 (
      .clk(clk), .reset_n(reset_n), .bus(bus16), .in_port(in_port),
      .out_port(out16), .oe(oe16), .irq(irq16));

   hpi_pio_ext #(.WIDTH(16), .EDGE_TYPE(2), .SYNC_STAGES(2), .RESET_OUT(16'h00A5)) dut_any (
      .clk(clk), .reset_n(reset_n), .bus(bus_any), .in_port(in_port),
      .out_port(out_any), .oe(oe_any), .irq(irq_any));

   hpi_pio_ext #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .RESET_OUT(8'h00)) dut8 (
      .clk(clk), .reset_n(reset_n), .bus(bus8), .in_port(in_port[7:0]),
      .out_port(out8), .oe(oe8), .irq(irq8));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] v);
      @(negedge clk);
      address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0;
      v = bus16.readdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'd0; in_port = 16'h0000;
      #12;
      check("rst_out", {16'd0, out16}, 32'h0000_00A5);
      check("rst_irq", {31'd0, irq16}, 32'd0);
      check("rst_readdata", bus16.readdata, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);

      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         check($sformatf("rd_reset_%0d", a), d, 32'd0);
      end
      check("reset_oe", {16'd0, oe16}, 32'd0);
      check("reset_out", {16'd0, out16}, 32'h0000_00A5);
      check("reset_irq", {31'd0, irq16}, 32'd0);

      wr(ADDR_DATA, 32'h0000_00F0);   check("out_data",   {16'd0, out16}, 32'h0000_00F0);
      wr(ADDR_OUTSET, 32'h0000_0003); check("out_set",    {16'd0, out16}, 32'h0000_00F3);
      wr(ADDR_OUTCLR, 32'h0000_0010); check("out_clr",    {16'd0, out16}, 32'h0000_00E3);

      @(negedge clk);
      address = ADDR_DATA; writedata = 32'h0000_FFFF; chipselect = 1'b0; write_n = 1'b0;
      @(posedge clk); #1;
      write_n = 1'b1;
      check("nocs_ignored", {16'd0, out16}, 32'h0000_00E3);
      wr(3'd6, 32'h0000_FFFF);        check("rsvd_ignored", {16'd0, out16}, 32'h0000_00E3);
      rd(ADDR_DIR, d);                check("rsvd_dir", d, 32'd0);
      wr(ADDR_DIR, 32'h0000_FFFF);    check("oe_dir", {16'd0, oe16}, 32'h0000_FFFF);
      rd(ADDR_DIR, d);                check("rd_dir", d, 32'h0000_FFFF);
      wr(ADDR_DIR, 32'h0000_0000);

      // rising edge on bit 2 with mask on bit 2
      wr(ADDR_IRQMASK, 32'h0000_0004);
      @(negedge clk);
      address = ADDR_EDGECAP; in_port = 16'h0004;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("cap_e2", bus16.readdata, 32'd0);
      @(posedge clk); #1;
      check("cap_e3", bus16.readdata, 32'd0);
      check("irq_e3", {31'd0, irq16}, 32'd0);
      @(posedge clk); #1;
      check("cap_e4", bus16.readdata, 32'h0000_0004);
      check("irq_e4", {31'd0, irq16}, 32'd1);
      wr(ADDR_EDGECAP, 32'h0000_0004);
      check("irq_clr_same", {31'd0, irq16}, 32'd1);
      @(posedge clk); #1;
      check("irq_clr_next", {31'd0, irq16}, 32'd0);

      // edge on bit 5 coinciding with a clear of bit 5
      @(negedge clk);
      in_port = 16'h0024;
      @(posedge clk);
      @(posedge clk);
      wr(ADDR_EDGECAP, 32'h0000_0020);
      rd(ADDR_EDGECAP, d);            check("setwins", d, 32'h0000_0020);
      wr(ADDR_EDGECAP, 32'h0000_0020);
      rd(ADDR_EDGECAP, d);            check("clr_again", d, 32'd0);
      check("irq_bit5", {31'd0, irq16}, 32'd0);

      // any-edge mode versus rising mode on bit 0
      wr(ADDR_EDGECAP, 32'h0000_FFFF);
      @(negedge clk); in_port = 16'h0025;
      @(negedge clk); in_port = 16'h0024;
      repeat (6) @(posedge clk);
      rd(ADDR_EDGECAP, d);
      check("pulse_rise", d, 32'h0000_0001);
      check("pulse_any", bus_any.readdata, 32'h0000_0001);
      wr(ADDR_EDGECAP, 32'h0000_0001);
      repeat (6) @(posedge clk);
      rd(ADDR_EDGECAP, d);
      check("any_cleared", bus_any.readdata, 32'd0);
      @(negedge clk); in_port = 16'h0025;
      repeat (6) @(posedge clk);
      rd(ADDR_EDGECAP, d);
      check("rise_new", d, 32'h0000_0001);
      check("any_new", bus_any.readdata, 32'h0000_0001);
      wr(ADDR_EDGECAP, 32'h0000_0001);
      @(negedge clk); in_port = 16'h0024;
      repeat (6) @(posedge clk);
      rd(ADDR_EDGECAP, d);
      check("rise_fall_ign", d, 32'd0);
      check("any_fall", bus_any.readdata, 32'h0000_0001);

      // width 8 truncation
      wr(ADDR_DATA, 32'hFFFF_FFFF);
      check("w8_out", {24'd0, out8}, 32'h0000_00FF);
      check("w16_out", {16'd0, out16}, 32'h0000_FFFF);
      wr(ADDR_DIR, 32'hFFFF_FFFF);
      rd(ADDR_DIR, d);
      check("w8_rd", bus8.readdata, 32'h0000_00FF);
      check("w16_rd", d, 32'h0000_FFFF);

      // reset in the middle of a pending interrupt
      @(negedge clk); in_port = 16'h0000;
      repeat (6) @(posedge clk);
      wr(ADDR_EDGECAP, 32'h0000_FFFF);
      @(negedge clk); in_port = 16'h0004; address = ADDR_EDGECAP;
      repeat (6) @(posedge clk); #1;
      check("pre_rst_irq", {31'd0, irq16}, 32'd1);
      check("pre_rst_cap", bus16.readdata, 32'h0000_0004);
      #2 reset_n = 1'b0;
      #1;
      check("async_irq", {31'd0, irq16}, 32'd0);
      check("async_rd", bus16.readdata, 32'd0);
      check("async_out", {16'd0, out16}, 32'h0000_00A5);
      check("async_oe", {16'd0, oe16}, 32'd0);
      in_port = 16'hFFFF;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wr(ADDR_IRQMASK, 32'h0000_FFFF);
      repeat (10) @(posedge clk);
      rd(ADDR_EDGECAP, d);
      check("post_rst_cap", d, 32'd0);
      check("post_rst_cap_any", bus_any.readdata, 32'd0);
      check("post_rst_irq", {31'd0, irq16}, 32'd0);
      check("post_rst_irq_any", {31'd0, irq_any}, 32'd0);
      rd(ADDR_DATA, d);
      check("post_rst_in", d, 32'h0000_FFFF);
      check("post_rst_in8", bus8.readdata, 32'h0000_00FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hpi_pio_ext.md
HPI_PIO_EXT -- requirements
Module: hpi_pio_ext

Interface
REQ-001 Parameters (name, default, meaning):
- WIDTH, 16: port width in bits, legal range 1..32.
- EDGE_TYPE, 0: capture mode; 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.
- RESET_OUT, 0: reset value of the output register, WIDTH bits.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- address, in, 3: register select.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- readdata, out, 32: registered read data.
- in_port, in, WIDTH: external inputs, asynchronous to clk.
- out_port, out, WIDTH: output register value.
- oe, out, WIDTH: per-bit output enable, equal to the direction register.
- irq, out, 1: registered interrupt request.

Function
REQ-003 Register map:
- 0 data: read returns the synchronised input; write loads the output register.
- 1 direction: 1 = output.
- 2 irqmask.
- 3 edgecapture: write-1-to-clear.
- 4 outset: write only; out |= wd.
- 5 outclear: write only; out &= ~wd.
- 6 and 7 reserved.
REQ-004 Write condition: chipselect=1 and write_n=0; the write takes effect on that rising clk edge. Only writedata[WIDTH-1:0] is used.
REQ-005 readdata is updated every cycle from address. Read latency is 1 cycle. Bits [31:WIDTH] read 0. Addresses 4-7 read 0. Reads have no side effects.
REQ-006 in_port passes through SYNC_STAGES flops. The data register read and the edge detector use the last stage only.
REQ-007 Edge detector holds a one-cycle-delayed copy of the synchronised input. A bit's edge condition is:
- rising: prev=0 and cur=1.
- falling: prev=1 and cur=0.
- any: prev differs from cur.
Edge-to-capture latency is SYNC_STAGES+1 cycles after in_port changes.
REQ-008 An edge condition sets the corresponding edgecapture bit. The bit stays set until cleared by software.
REQ-009 A clear and an edge on the same bit in the same cycle leave the bit set (set wins).
REQ-010 irq is registered: irq <= |(edgecapture & irqmask), evaluated on register values. irq asserts 1 cycle after the capture bit sets and deasserts 1 cycle after the clear or mask write.
REQ-011 out_port reflects the output register for all bits, regardless of direction. oe = direction.
REQ-012 Edge detection runs for every bit, input or output direction alike.
REQ-013 Writes to reserved addresses are ignored. Writes with chipselect=0 are ignored.

Reset
REQ-014 When reset_n=0, the following are forced asynchronously:
- output register = RESET_OUT.
- direction, irqmask, edgecapture = 0.
- readdata = 0, irq = 0.
- synchroniser and edge-history flops = 0.
REQ-015 After reset_n deasserts, no edge is captured in the first SYNC_STAGES+1 cycles. Edge history is preloaded from the synchroniser output during this window, so inputs already high at reset release do not produce spurious rising captures.
REQ-016 Reset asserted mid-write discards the write. Reset mid-operation clears pending captures and drops irq within the same cycle.

Structure
REQ-017 A shared package hpi_pio_pkg holds:
- address constants ADDR_DATA..ADDR_OUTCLR.
- edge-mode constants EDGE_RISE, EDGE_FALL, EDGE_ANY.
REQ-018 One sub-module, hpi_pio_sync_edge, implements the synchroniser, edge history and per-bit edge pulse output. Its parameters are WIDTH, SYNC_STAGES and EDGE_TYPE. The register file and bus logic stay in the top level.
REQ-019 Target size: 120-400 lines of RTL in total.

Verification
REQ-020 Reset/readback: WIDTH=16, RESET_OUT=16'h00A5. Release reset, then read addresses 0-7 → out_port=00A5, oe=0, irq=0, reads of addresses 1-7 return 0.
REQ-021 Set/clear: write data=16'h00F0, outset=16'h0003, outclear=16'h0010 → out_port 00F0, then 00F3, then 00E3, each visible 1 cycle after its write.
REQ-022 Edge and interrupt: EDGE_TYPE=0, irqmask=16'h0004; drive in_port[2] 0→1 → edgecapture=0004 at SYNC_STAGES+1 cycles, irq=1 one cycle later. Write 0004 to address 3 → irq=0 one cycle later.
REQ-023 Simultaneous set/clear: an edge on bit 5 coincides with a write-1-to-clear of bit 5 → edgecapture bit 5 stays 1. A repeat clear with no edge → bit 5 = 0.
REQ-024 Modes and width: EDGE_TYPE=2 with pulse 0→1→0 on bit 0 → captured, and remains captured after clear only if a new edge occurs. WIDTH=8: write 32'hFFFF_FFFF to data → out_port=FF; readdata[31:8]=0.
REQ-025 Reset mid-operation: edgecapture=0004 with irq=1; assert reset_n=0 → irq=0, edgecapture=0 asynchronously. After release, in_port held at FFFF produces no captures.
